// File: rtl/booth_mac_accum_pkg.sv
// booth_mac_accum_pkg
// Shared definitions for the accumulate half of the sequential MAC datapath:
//   - state_t      : FSM state encoding (binary)
//   - DEF_PROD_W   : default product width (multiplier c_out width)
//   - DEF_ACC_W    : default accumulator width
//   - DEF_CNT_W    : default frame-length counter width
//   - sat_max/min  : largest / smallest two's-complement value for a width
package booth_mac_accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEF_PROD_W = 16;
  localparam int DEF_ACC_W  = 20;
  localparam int DEF_CNT_W  = 4;

  // Largest positive signed value representable in w bits.
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Most negative signed value representable in w bits.
  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/booth_mac_accum_sat_add.sv
// sat_add_signed
// Combinational signed add of an ACC_W-bit accumulator and a PROD_W-bit
// addend, clamped to the ACC_W-bit signed range.
// Ports:
//   acc_in : ACC_W-bit signed running value
//   add_in : PROD_W-bit signed addend (sign-extended internally)
//   sum    : ACC_W-bit signed clamped result
//   sat    : high when the result was clamped
// ACC_W must be >= PROD_W.
module sat_add_signed
  import booth_mac_accum_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int PROD_W = DEF_PROD_W
) (
  input  logic signed [ACC_W-1:0]  acc_in,
  input  logic signed [PROD_W-1:0] add_in,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     sat
);

  // One guard bit is enough: |acc| + |add| cannot exceed 2**ACC_W.
  localparam logic signed [ACC_W:0] MAX_W = (ACC_W + 1)'(sat_max(ACC_W));
  localparam logic signed [ACC_W:0] MIN_W = (ACC_W + 1)'(sat_min(ACC_W));

  logic signed [ACC_W:0] acc_ext;
  logic signed [ACC_W:0] add_ext;
  logic signed [ACC_W:0] wide;

  assign acc_ext = {acc_in[ACC_W-1], acc_in};
  assign add_ext = {{(ACC_W + 1 - PROD_W){add_in[PROD_W-1]}}, add_in};
  assign wide    = acc_ext + add_ext;

  always_comb begin
    sum = wide[ACC_W-1:0];
    sat = 1'b0;
    if (wide > MAX_W) begin
      sum = MAX_W[ACC_W-1:0];
      sat = 1'b1;
    end else if (wide < MIN_W) begin
      sum = MIN_W[ACC_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/booth_mac_accum.sv
// booth_mac_accum
// Accumulates a frame of signed products from the Booth multiplier into a
// saturating ACC_W-bit sum and offers the result on a held output handshake.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start, frame_len    : begin a frame (IDLE only); length 0 means 2**CNT_W
//   prod_in, in_valid   : product stream; in_ready is high only in ACCUM
//   acc_out, out_valid  : frame result, held in DONE until out_ready
//   ovf                 : sticky saturation flag for the current/last frame
//   busy                : high in ACCUM or DONE
module booth_mac_accum
  import booth_mac_accum_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CNT_W-1:0]         frame_len,
  input  logic signed [PROD_W-1:0] prod_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     ovf,
  output logic                     busy
);

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     ovf_q, ovf_d;
  // One extra bit so a full 2**CNT_W frame is representable without wrap.
  logic [CNT_W:0]           cnt_q, cnt_d;
  logic [CNT_W:0]           len_q, len_d;

  logic signed [ACC_W-1:0]  sum;
  logic                     sat;
  logic [CNT_W:0]           cnt_inc;
  logic                     accept;

  sat_add_signed #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_sat_add (
    .acc_in (acc_q),
    .add_in (prod_in),
    .sum    (sum),
    .sat    (sat)
  );

  assign accept  = in_valid && (state_q == ST_ACCUM);
  assign cnt_inc = cnt_q + 1'b1;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = (frame_len == '0) ? ((CNT_W + 1)'(1) << CNT_W)
                                      : {1'b0, frame_len};
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          acc_d = sum;
          ovf_d = ovf_q | sat;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // A start coinciding with this handshake is deliberately dropped.
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    in_ready  = (state_q == ST_ACCUM);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_ACCUM) || (state_q == ST_DONE);
    acc_out   = acc_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_booth_mac_accum.sv
// tb_booth_mac_accum
// Directed checks of booth_mac_accum. Two instances share all inputs: one at
// the default 20-bit accumulator, one at 16 bits so saturation is reachable.
module tb_booth_mac_accum;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [3:0]         frame_len;
  logic signed [15:0] prod_in;
  logic               in_valid;
  logic               out_ready;

  logic               in_ready_a, out_valid_a, ovf_a, busy_a;
  logic signed [19:0] acc_out_a;
  logic               in_ready_b, out_valid_b, ovf_b, busy_b;
  logic signed [15:0] acc_out_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  booth_mac_accum #(.PROD_W(16), .ACC_W(20), .CNT_W(4)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .frame_len (frame_len),
    .prod_in   (prod_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .acc_out   (acc_out_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .ovf       (ovf_a),
    .busy      (busy_a)
  );

  booth_mac_accum #(.PROD_W(16), .ACC_W(16), .CNT_W(4)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .frame_len (frame_len),
    .prod_in   (prod_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .acc_out   (acc_out_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .ovf       (ovf_b),
    .busy      (busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    frame_len = 4'd0;
    prod_in   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    $display("txn reset");
    chk("rst_acc", acc_out_a, 0);
    chk("rst_out_valid", 32'(out_valid_a), 0);
    chk("rst_in_ready", 32'(in_ready_a), 0);
    chk("rst_ovf", 32'(ovf_a), 0);
    chk("rst_busy", 32'(busy_a), 0);

    // in_valid in IDLE is ignored
    in_valid = 1'b1; prod_in = 16'sd1234;
    tick();
    $display("txn idle_in_valid");
    chk("idle_acc", acc_out_a, 0);
    chk("idle_in_ready", 32'(in_ready_a), 0);
    chk("idle_busy", 32'(busy_a), 0);
    in_valid = 1'b0;

    // Basic frame: 100, -50, 25; start pulse mid-frame must be ignored
    start = 1'b1; frame_len = 4'd3;
    tick();
    start = 1'b0;
    $display("txn basic_start");
    chk("basic_busy", 32'(busy_a), 1);
    chk("basic_in_ready", 32'(in_ready_a), 1);
    in_valid = 1'b1; prod_in = 16'sd100;
    tick();
    prod_in = -16'sd50; start = 1'b1; frame_len = 4'd1;
    tick();
    $display("txn basic_two_accepts");
    chk("basic_acc2", acc_out_a, 50);
    chk("basic_not_done", 32'(out_valid_a), 0);
    start = 1'b0; prod_in = 16'sd25;
    tick();
    in_valid = 1'b0;
    $display("txn basic_done");
    chk("basic_out_valid", 32'(out_valid_a), 1);
    chk("basic_acc", acc_out_a, 75);
    chk("basic_ovf", 32'(ovf_a), 0);
    chk("basic_done_in_ready", 32'(in_ready_a), 0);
    chk("basic_acc_b", acc_out_b, 75);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    $display("txn basic_handshake");
    chk("basic_hs_out_valid", 32'(out_valid_a), 0);
    chk("basic_hs_in_ready", 32'(in_ready_a), 0);
    chk("basic_hs_busy", 32'(busy_a), 0);
    chk("basic_hs_acc_held", acc_out_a, 75);

    // Gaps and backpressure: 16384, gap, -16384
    start = 1'b1; frame_len = 4'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b1; prod_in = 16'sd16384;
    tick();
    in_valid = 1'b0;
    chk("gap_acc1", acc_out_a, 16384);
    for (int i = 0; i < 3; i++) tick();
    $display("txn gap_idle_cycles");
    chk("gap_acc_hold", acc_out_a, 16384);
    chk("gap_not_done", 32'(out_valid_a), 0);
    in_valid = 1'b1; prod_in = -16'sd16384;
    tick();
    in_valid = 1'b0;
    chk("gap_done", 32'(out_valid_a), 1);
    chk("gap_acc", acc_out_a, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      $display("txn backpressure cycle %0d", i);
      chk("bp_out_valid", 32'(out_valid_a), 1);
      chk("bp_acc", acc_out_a, 0);
      chk("bp_ovf", 32'(ovf_a), 0);
      chk("bp_in_ready", 32'(in_ready_a), 0);
    end
    // start coincident with handshake is dropped
    out_ready = 1'b1; start = 1'b1;
    tick();
    out_ready = 1'b0; start = 1'b0;
    $display("txn handshake_with_start");
    chk("hs_start_busy", 32'(busy_a), 0);
    chk("hs_start_out_valid", 32'(out_valid_a), 0);
    tick();
    chk("hs_start_still_idle", 32'(busy_a), 0);

    // Saturation on the 16-bit instance: 16384, 16384, -100
    start = 1'b1; frame_len = 4'd3;
    tick();
    start = 1'b0;
    in_valid = 1'b1; prod_in = 16'sd16384;
    tick();
    tick();
    $display("txn sat_two_products");
    chk("sat_b_clamp", acc_out_b, 32767);
    chk("sat_b_ovf", 32'(ovf_b), 1);
    chk("sat_a_noclamp", acc_out_a, 32768);
    chk("sat_a_ovf", 32'(ovf_a), 0);
    prod_in = -16'sd100;
    tick();
    in_valid = 1'b0;
    $display("txn sat_done");
    chk("sat_b_final", acc_out_b, 32667);
    chk("sat_b_ovf_final", 32'(ovf_b), 1);
    chk("sat_b_done", 32'(out_valid_b), 1);
    chk("sat_a_final", acc_out_a, 32668);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Full frame (frame_len=0 -> 16); the start also clears ovf
    start = 1'b1; frame_len = 4'd0;
    tick();
    start = 1'b0;
    $display("txn full_start");
    chk("full_b_ovf_clear", 32'(ovf_b), 0);
    chk("full_b_acc_clear", acc_out_b, 0);
    in_valid = 1'b1; prod_in = 16'sd16384;
    for (int i = 0; i < 15; i++) tick();
    chk("full_15_in_ready", 32'(in_ready_a), 1);
    chk("full_15_not_done", 32'(out_valid_a), 0);
    tick();
    $display("txn full_16_accepts");
    chk("full_in_ready", 32'(in_ready_a), 0);
    chk("full_out_valid", 32'(out_valid_a), 1);
    chk("full_acc", acc_out_a, 262144);
    chk("full_ovf", 32'(ovf_a), 0);
    chk("full_b_acc", acc_out_b, 32767);
    chk("full_b_ovf", 32'(ovf_b), 1);
    tick();
    chk("full_17th_ignored", acc_out_a, 262144);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset mid-frame
    start = 1'b1; frame_len = 4'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1; prod_in = 16'sd1000;
    tick();
    prod_in = 16'sd2000;
    tick();
    in_valid = 1'b0;
    chk("mid_acc", acc_out_a, 3000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    $display("txn reset_mid_frame");
    chk("mid_rst_acc", acc_out_a, 0);
    chk("mid_rst_out_valid", 32'(out_valid_a), 0);
    chk("mid_rst_busy", 32'(busy_a), 0);
    chk("mid_rst_in_ready", 32'(in_ready_a), 0);
    in_valid = 1'b1; prod_in = 16'sd500;
    tick();
    tick();
    in_valid = 1'b0;
    $display("txn post_reset_in_valid");
    chk("post_rst_acc", acc_out_a, 0);
    chk("post_rst_busy", 32'(busy_a), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_mac_accum.md
Name: booth_mac_accum

Overview:
- Downstream consumer of the signed 8x8 Booth multiplier.
- Accepts a frame of FRAME-length signed 16-bit products over a valid/ready handshake.
- Accumulates the products with saturation into an ACC_W-bit signed sum.
- Presents the sum on a held output handshake, forming the accumulate half of a sequential MAC datapath.

Parameters:
PROD_W, 16, product width (the multiplier's c_out width)
ACC_W, 20, accumulator width; must be >= PROD_W
CNT_W, 4, frame-length counter width; maximum frame = 2**CNT_W products

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a frame; honoured only in IDLE
frame_len  input  CNT_W  products per frame, sampled on accepted start; 0 means 2**CNT_W
prod_in  input  PROD_W  signed product from the multiplier
in_valid  input  1  prod_in is valid
in_ready  output  1  block accepts a product this cycle
acc_out  output  ACC_W  signed accumulated sum
out_valid  output  1  acc_out holds a completed frame result
out_ready  input  1  consumer takes acc_out
ovf  output  1  sticky saturation flag for the current/last frame
busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset (sync, active-high, highest priority, also mid-frame): state=IDLE; acc_out=0, out_valid=0, in_ready=0, ovf=0, busy=0; internal count and length cleared.
- States: IDLE, ACCUM, DONE. Binary encoding, taken from the package.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - On start=1: latch frame_len into len_q (0 maps to 2**CNT_W), clear acc_out to 0, ovf to 0 and count to 0, then go to ACCUM.
  - acc_out keeps the previous result until the next start.
- ACCUM:
  - in_ready=1 combinationally, so in_valid & in_ready is an accept.
  - On accept: acc_out <= sat(acc_out + sign_ext(prod_in)); count <= count+1.
  - When the accept brings count to len_q, go to DONE in that same edge.
  - No accept means hold. start is ignored.
- DONE:
  - out_valid=1, in_ready=0. acc_out and ovf stay stable while out_ready=0, with no timeout.
  - On out_valid & out_ready: go to IDLE, and out_valid=0 from the next cycle.
  - start in the same cycle as the handshake is ignored; it must be re-asserted in IDLE.
- Latency:
  - The last product's accept edge is followed by out_valid=1 in the next cycle.
  - Minimum frame time: 1 (start) + N (products) + 1 (handshake) cycles.
- Arithmetic:
  - prod_in is sign-extended to ACC_W+1 bits and added as two's complement.
  - If the result exceeds 2**(ACC_W-1)-1, clamp to that value; if below -2**(ACC_W-1), clamp to that value.
  - Any clamp sets ovf, which stays set until the next accepted start or reset.
  - Later products continue accumulating from the clamped value.
- Counter: CNT_W+1 bits wide, so that a full 2**CNT_W frame is representable; it never wraps within a frame.
- With default widths, 16 products of the 8x8 range (max magnitude 16384) never saturate. Saturation is reachable only with a smaller ACC_W.

Decomposition:
- Shared package:
  - State enum constants ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_DONE=2'd2.
  - Default width constants PROD_W and ACC_W.
  - Saturation bound helpers (max and min signed value for a width).
- One sub-module, sat_add_signed:
  - Combinational ACC_W + PROD_W signed add with clamp.
  - Outputs sum[ACC_W-1:0] and sat flag.
  - Reusable by later datapath blocks.
- FSM, counter and registers live in booth_mac_accum.

Test Plan:
- Basic frame: start with frame_len=3; accept 100, -50, 25 back-to-back -> out_valid=1 the cycle after the third accept, acc_out=75, ovf=0; out_ready=1 -> IDLE next cycle, in_ready=0.
- Backpressure/gaps: frame_len=2; in_valid low 3 cycles between 16384 and -16384 -> acc_out=0 only after the second accept. Then hold out_ready=0 for 5 cycles -> out_valid, acc_out, ovf unchanged and in_ready=0 throughout.
- Saturation (ACC_W=16): frame_len=3; products 16384, 16384, -100 -> clamps to 32767 after the second product; final acc_out=32667, ovf=1. The next start clears ovf to 0.
- Full frame: frame_len=0; 16 products of 16384 -> exactly 16 accepts, a 17th in_valid is not accepted (in_ready=0), acc_out=262144, ovf=0.
- Reset mid-frame: frame_len=4, two products accepted, reset=1 for one cycle -> the next cycle shows acc_out=0, out_valid=0, busy=0, IDLE. Later in_valid pulses are ignored until start.
- Ignored controls:
  - start pulses in ACCUM do not restart the frame or relatch frame_len.
  - start coincident with the DONE handshake leaves the block in IDLE with busy=0.
  - in_valid in IDLE does not change acc_out.
